// File: rtl/simple_pkg.sv
// Shared encodings for the SIMPLE core instruction sequencer: FSM states,
// opcode classes, immediate/branch sub-codes, branch conditions and strobe values.
package simple_pkg;

  typedef enum logic [2:0] {
    ST_FETCH = 3'd0,
    ST_EXEC  = 3'd1,
    ST_MEM   = 3'd2,
    ST_WB    = 3'd3,
    ST_HALT  = 3'd4
  } state_t;

  localparam logic [1:0] OP_LD  = 2'b00;
  localparam logic [1:0] OP_ST  = 2'b01;
  localparam logic [1:0] OP_IMM = 2'b10;
  localparam logic [1:0] OP_ALU = 2'b11;

  localparam logic [2:0] IMM_LI  = 3'b000;
  localparam logic [2:0] IMM_B   = 3'b100;
  localparam logic [2:0] IMM_BCC = 3'b111;

  localparam logic [2:0] COND_BE  = 3'b000;
  localparam logic [2:0] COND_BLT = 3'b001;
  localparam logic [2:0] COND_BLE = 3'b010;
  localparam logic [2:0] COND_BNE = 3'b011;

  localparam logic [3:0] ALU_NONE = 4'b1111;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MDR = 2'b01;
  localparam logic [1:0] WB_IMM = 2'b10;

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Conditional-branch evaluator: IR[10:8] condition code against the Z/S/V flags.
// Unlisted condition codes are never taken, so they behave as NOPs.
module branch_cond
  import simple_pkg::*;
(
  input  logic [2:0] i_cond,
  input  logic       i_flag_z,
  input  logic       i_flag_s,
  input  logic       i_flag_v,
  output logic       o_taken
);

  always_comb begin
    o_taken = 1'b0;
    case (i_cond)
      COND_BE:  o_taken = i_flag_z;
      COND_BLT: o_taken = i_flag_s ^ i_flag_v;
      COND_BLE: o_taken = i_flag_z | (i_flag_s ^ i_flag_v);
      COND_BNE: o_taken = ~i_flag_z;
      default:  o_taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/seq_control.sv
// Multi-cycle fetch/exec/mem/wb sequencer for the 16-bit SIMPLE core.
// Optional memory-timeout watchdog is enabled by defining SEQ_BUS_TIMEOUT_EN.
module seq_control
  import simple_pkg::*;
#(
  parameter logic [15:0] PC_RESET = 16'h0000
) (
  input  logic        CLOCK,
  input  logic        RESET,
  output logic        MEM_REQ,
  output logic        MEM_WE,
  output logic [15:0] MEM_ADDR,
  input  logic [15:0] MEM_RDATA,
  input  logic        MEM_ACK,
  input  logic [15:0] EA,
  input  logic        FLAG_Z,
  input  logic        FLAG_S,
  input  logic        FLAG_V,
  output logic [15:0] IR,
  output logic [15:0] PC,
  output logic [15:0] MDR,
  output logic [3:0]  S_ALU,
  output logic        REG_WE,
  output logic        FLAG_WE,
  output logic [1:0]  WB_SEL,
  output logic        HALTED,
  output logic        BUS_ERR
);

  state_t      r_state;
  state_t      w_state_next;
  logic        r_run;
  logic [15:0] r_pc;
  logic [15:0] r_ir;
  logic [15:0] r_mdr;
  logic [1:0]  w_op;
  logic [2:0]  w_sub;
  logic        w_cond_taken;
  logic        w_branch;
  logic        w_timeout;

  assign w_op  = r_ir[15:14];
  assign w_sub = r_ir[13:11];

  branch_cond u_branch_cond (
    .i_cond   (r_ir[10:8]),
    .i_flag_z (FLAG_Z),
    .i_flag_s (FLAG_S),
    .i_flag_v (FLAG_V),
    .o_taken  (w_cond_taken)
  );

  assign w_branch = (w_op == OP_IMM) &&
                    ((w_sub == IMM_B) || ((w_sub == IMM_BCC) && w_cond_taken));

`ifdef SEQ_BUS_TIMEOUT_EN
  logic [7:0] r_wait_cnt;
  logic       r_bus_err;

  // Counter only runs while a request is outstanding, so it is zero on every FETCH/MEM entry.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_wait_cnt <= 8'd0;
      r_bus_err  <= 1'b0;
    end else begin
      if (!MEM_REQ || MEM_ACK)
        r_wait_cnt <= 8'd0;
      else if (r_wait_cnt != 8'd255)
        r_wait_cnt <= r_wait_cnt + 8'd1;
      if (w_timeout)
        r_bus_err <= 1'b1;
    end
  end

  assign w_timeout = MEM_REQ && !MEM_ACK && (r_wait_cnt == 8'd254);
  assign BUS_ERR   = r_bus_err;
`else
  assign w_timeout = 1'b0;
  assign BUS_ERR   = 1'b0;
`endif

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET)
      r_state <= ST_FETCH;
    else
      r_state <= w_state_next;
  end

  // r_run holds MEM_REQ low for the reset cycle itself, while the state is already FETCH.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      r_run <= 1'b0;
      r_pc  <= PC_RESET;
      r_ir  <= 16'h0000;
      r_mdr <= 16'h0000;
    end else begin
      r_run <= 1'b1;
      if (r_state == ST_FETCH && r_run && MEM_ACK) begin
        r_ir <= MEM_RDATA;
        r_pc <= r_pc + 16'd1;
      end else if (r_state == ST_EXEC && w_branch) begin
        r_pc <= r_pc + sext8(r_ir[7:0]);
      end
      if (r_state == ST_MEM && MEM_ACK && w_op == OP_LD)
        r_mdr <= MEM_RDATA;
    end
  end

  always_comb begin
    w_state_next = r_state;
    MEM_REQ      = 1'b0;
    MEM_WE       = 1'b0;
    MEM_ADDR     = r_pc;
    S_ALU        = ALU_NONE;
    REG_WE       = 1'b0;
    FLAG_WE      = 1'b0;
    WB_SEL       = WB_ALU;
    case (r_state)
      ST_FETCH: begin
        MEM_REQ = r_run;
        if (r_run && MEM_ACK)
          w_state_next = ST_EXEC;
      end
      ST_EXEC: begin
        w_state_next = ST_FETCH;
        case (w_op)
          OP_ALU: begin
            if (r_ir[7:4] == ALU_NONE) begin
              w_state_next = ST_HALT;
            end else begin
              S_ALU   = r_ir[7:4];
              REG_WE  = 1'b1;
              FLAG_WE = 1'b1;
            end
          end
          OP_LD, OP_ST: w_state_next = ST_MEM;
          default: begin
            if (w_sub == IMM_LI) begin
              REG_WE = 1'b1;
              WB_SEL = WB_IMM;
            end
          end
        endcase
      end
      ST_MEM: begin
        MEM_REQ  = 1'b1;
        MEM_WE   = (w_op == OP_ST);
        MEM_ADDR = EA;
        if (MEM_ACK)
          w_state_next = (w_op == OP_ST) ? ST_FETCH : ST_WB;
      end
      ST_WB: begin
        REG_WE       = 1'b1;
        WB_SEL       = WB_MDR;
        w_state_next = ST_FETCH;
      end
      ST_HALT: w_state_next = ST_HALT;
      default: w_state_next = ST_FETCH;
    endcase
    if (w_timeout)
      w_state_next = ST_HALT;
  end

  assign IR     = r_ir;
  assign PC     = r_pc;
  assign MDR    = r_mdr;
  assign HALTED = (r_state == ST_HALT);

endmodule

// File: tb/tb_seq_control.sv
// Self-checking bench for seq_control: table of single-word instructions plus
// hand-written LD/ST/HLT/reset sequences; strobes checked through a scoreboard queue.
module tb_seq_control;

  logic        CLOCK;
  logic        RESET;
  logic        MEM_REQ;
  logic        MEM_WE;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_RDATA;
  logic        MEM_ACK;
  logic [15:0] EA;
  logic        FLAG_Z;
  logic        FLAG_S;
  logic        FLAG_V;
  logic [15:0] IR;
  logic [15:0] PC;
  logic [15:0] MDR;
  logic [3:0]  S_ALU;
  logic        REG_WE;
  logic        FLAG_WE;
  logic [1:0]  WB_SEL;
  logic        HALTED;
  logic        BUS_ERR;

  seq_control dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .MEM_ADDR(MEM_ADDR),
    .MEM_RDATA(MEM_RDATA), .MEM_ACK(MEM_ACK), .EA(EA),
    .FLAG_Z(FLAG_Z), .FLAG_S(FLAG_S), .FLAG_V(FLAG_V),
    .IR(IR), .PC(PC), .MDR(MDR), .S_ALU(S_ALU),
    .REG_WE(REG_WE), .FLAG_WE(FLAG_WE), .WB_SEL(WB_SEL),
    .HALTED(HALTED), .BUS_ERR(BUS_ERR)
  );

  initial CLOCK = 1'b0;
  always #5 CLOCK = ~CLOCK;

  int n_checks = 0;
  int n_fail   = 0;

  // Expected strobe bundle {S_ALU, REG_WE, FLAG_WE, WB_SEL}
  logic [7:0] sb[$];

  typedef struct {
    string       nm;
    logic [15:0] instr;
    logic [2:0]  zsv;
    int          waits;
    bit          strobe;
    logic [3:0]  s_alu;
    logic        reg_we;
    logic        flag_we;
    logic [1:0]  wb;
    logic [15:0] next_pc;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input string nm, input logic [15:0] instr, input logic [2:0] zsv,
                              input int waits, input bit strobe, input logic [3:0] s_alu,
                              input logic reg_we, input logic flag_we, input logic [1:0] wb,
                              input logic [15:0] next_pc);
    vec_t v;
    v.nm = nm; v.instr = instr; v.zsv = zsv; v.waits = waits; v.strobe = strobe;
    v.s_alu = s_alu; v.reg_we = reg_we; v.flag_we = flag_we; v.wb = wb; v.next_pc = next_pc;
    return v;
  endfunction

  task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Strobe monitor: any active strobe must match the oldest expected entry.
  always @(negedge CLOCK) begin
    logic [7:0] got;
    logic [7:0] e;
    got = {S_ALU, REG_WE, FLAG_WE, WB_SEL};
    if (RESET && (REG_WE || FLAG_WE || S_ALU != 4'hF)) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL strobe_unexpected: got %h expected none at PC %h", got, PC);
      end else begin
        e = sb.pop_front();
        if (got !== e) begin
          n_fail++;
          $display("FAIL strobe: got %h expected %h at PC %h", got, e, PC);
        end
      end
    end
  end

  // Serve one memory request; called at a negedge, returns at the negedge after the ack edge.
  task automatic serve(input string nm, input logic [15:0] addr, input logic we,
                       input logic [15:0] rdata, input int waits);
    int n;
    n = 0;
    while (!MEM_REQ && n < 20) begin
      @(negedge CLOCK);
      n++;
    end
    check({nm, " req"}, {15'd0, MEM_REQ}, 16'd1);
    check({nm, " addr"}, MEM_ADDR, addr);
    check({nm, " we"}, {15'd0, MEM_WE}, {15'd0, we});
    for (int w = 0; w < waits; w++) begin
      @(negedge CLOCK);
      check({nm, " wait req"}, {15'd0, MEM_REQ}, 16'd1);
      check({nm, " wait addr"}, MEM_ADDR, addr);
    end
    MEM_ACK   = 1'b1;
    MEM_RDATA = rdata;
    @(negedge CLOCK);
    MEM_ACK   = 1'b0;
    MEM_RDATA = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_pc;
    int n;

    vt.push_back(mk("alu0",      16'hC000, 3'b000, 0, 1, 4'h0, 1, 1, 2'b00, 16'h0001));
    vt.push_back(mk("alu3",      16'hC035, 3'b000, 2, 1, 4'h3, 1, 1, 2'b00, 16'h0002));
    vt.push_back(mk("li",        16'h8012, 3'b000, 1, 1, 4'hF, 1, 0, 2'b10, 16'h0003));
    vt.push_back(mk("b_fwd",     16'hA002, 3'b000, 0, 0, 4'hF, 0, 0, 2'b00, 16'h0006));
    vt.push_back(mk("be_t",      16'hB801, 3'b100, 0, 0, 4'hF, 0, 0, 2'b00, 16'h0008));
    vt.push_back(mk("blt_t",     16'hB904, 3'b010, 1, 0, 4'hF, 0, 0, 2'b00, 16'h000D));
    vt.push_back(mk("ble_nt",    16'hBA05, 3'b011, 0, 0, 4'hF, 0, 0, 2'b00, 16'h000E));
    vt.push_back(mk("bne_nt",    16'hBB03, 3'b100, 0, 0, 4'hF, 0, 0, 2'b00, 16'h000F));
    vt.push_back(mk("bne_t",     16'hBB02, 3'b000, 0, 0, 4'hF, 0, 0, 2'b00, 16'h0012));
    vt.push_back(mk("blt_neg",   16'hB9F0, 3'b001, 0, 0, 4'hF, 0, 0, 2'b00, 16'h0003));
    vt.push_back(mk("ble_z",     16'hBA10, 3'b100, 0, 0, 4'hF, 0, 0, 2'b00, 16'h0014));
    vt.push_back(mk("bcc_nop",   16'hBC00, 3'b111, 0, 0, 4'hF, 0, 0, 2'b00, 16'h0015));
    vt.push_back(mk("imm_nop",   16'h9000, 3'b000, 0, 0, 4'hF, 0, 0, 2'b00, 16'h0016));
    vt.push_back(mk("b_to5",     16'hA0EE, 3'b000, 0, 0, 4'hF, 0, 0, 2'b00, 16'h0005));
    vt.push_back(mk("b_fc",      16'hA0FC, 3'b000, 0, 0, 4'hF, 0, 0, 2'b00, 16'h0002));
    vt.push_back(mk("b_to5b",    16'hA002, 3'b000, 0, 0, 4'hF, 0, 0, 2'b00, 16'h0005));
    vt.push_back(mk("bne_z",     16'hBB10, 3'b100, 0, 0, 4'hF, 0, 0, 2'b00, 16'h0006));
    vt.push_back(mk("aluA",      16'hC0A7, 3'b000, 3, 1, 4'hA, 1, 1, 2'b00, 16'h0007));
    vt.push_back(mk("be_nt",     16'hB800, 3'b011, 0, 0, 4'hF, 0, 0, 2'b00, 16'h0008));
    vt.push_back(mk("b_wrap_dn", 16'hA0F0, 3'b000, 0, 0, 4'hF, 0, 0, 2'b00, 16'hFFF9));
    vt.push_back(mk("b_wrap_up", 16'hA00A, 3'b000, 0, 0, 4'hF, 0, 0, 2'b00, 16'h0004));
    vt.push_back(mk("aluE",      16'hC1E5, 3'b000, 0, 1, 4'hE, 1, 1, 2'b00, 16'h0005));
    vt.push_back(mk("blt_nt",    16'hB903, 3'b011, 0, 0, 4'hF, 0, 0, 2'b00, 16'h0006));

    RESET = 1'b0; MEM_ACK = 1'b0; MEM_RDATA = 16'h0000; EA = 16'h0000;
    FLAG_Z = 1'b0; FLAG_S = 1'b0; FLAG_V = 1'b0;
    repeat (2) @(negedge CLOCK);
    check("rst mem_req", {15'd0, MEM_REQ}, 16'd0);
    check("rst mem_we", {15'd0, MEM_WE}, 16'd0);
    check("rst pc", PC, 16'h0000);
    check("rst ir", IR, 16'h0000);
    check("rst mdr", MDR, 16'h0000);
    check("rst strobes", {8'd0, S_ALU, REG_WE, FLAG_WE, WB_SEL}, 16'h00F0);
    check("rst halted/bus_err", {14'd0, HALTED, BUS_ERR}, 16'd0);

    RESET = 1'b1;
    @(negedge CLOCK);
    check("req after reset", {15'd0, MEM_REQ}, 16'd1);

    exp_pc = 16'h0000;
    for (int i = 0; i < vt.size(); i++) begin
      {FLAG_Z, FLAG_S, FLAG_V} = vt[i].zsv;
      if (vt[i].strobe)
        sb.push_back({vt[i].s_alu, vt[i].reg_we, vt[i].flag_we, vt[i].wb});
      serve({vt[i].nm, " fetch"}, exp_pc, 1'b0, vt[i].instr, vt[i].waits);
      check({vt[i].nm, " ir"}, IR, vt[i].instr);
      @(negedge CLOCK);
      check({vt[i].nm, " next pc"}, PC, vt[i].next_pc);
      check({vt[i].nm, " sb empty"}, 16'(sb.size()), 16'd0);
      $display("vec %0d %s instr=%h next_pc=%h", i, vt[i].nm, vt[i].instr, PC);
      exp_pc = vt[i].next_pc;
    end

    // LD at PC 6: three wait cycles, single WB strobe, spurious ack in WB ignored.
    {FLAG_Z, FLAG_S, FLAG_V} = 3'b000;
    EA = 16'h0040;
    sb.push_back({4'hF, 1'b1, 1'b0, 2'b01});
    serve("ld fetch", 16'h0006, 1'b0, 16'h0123, 0);
    check("ld exec req", {15'd0, MEM_REQ}, 16'd0);
    serve("ld mem", 16'h0040, 1'b0, 16'hBEEF, 3);
    check("ld mdr", MDR, 16'hBEEF);
    MEM_ACK = 1'b1; MEM_RDATA = 16'hDEAD;
    @(negedge CLOCK);
    MEM_ACK = 1'b0; MEM_RDATA = 16'h0000;
    check("ld pc", PC, 16'h0007);
    check("ld mdr kept", MDR, 16'hBEEF);
    check("ld ir kept", IR, 16'h0123);
    check("ld sb empty", 16'(sb.size()), 16'd0);
    $display("ld done mdr=%h pc=%h", MDR, PC);

    // ST at PC 7: MEM_WE only during the MEM phase, no register write.
    EA = 16'h1234;
    serve("st fetch", 16'h0007, 1'b0, 16'h4000, 0);
    check("st exec we", {15'd0, MEM_WE}, 16'd0);
    serve("st mem", 16'h1234, 1'b1, 16'h0000, 1);
    check("st we after", {15'd0, MEM_WE}, 16'd0);
    check("st next addr", MEM_ADDR, 16'h0008);
    check("st pc", PC, 16'h0008);
    $display("st done pc=%h", PC);

    // HLT at PC 8.
    serve("hlt fetch", 16'h0008, 1'b0, 16'hC0F0, 0);
    @(negedge CLOCK);
    check("hlt halted", {15'd0, HALTED}, 16'd1);
    check("hlt req", {15'd0, MEM_REQ}, 16'd0);
    MEM_ACK = 1'b1;
    @(negedge CLOCK);
    MEM_ACK = 1'b0;
    repeat (3) @(negedge CLOCK);
    check("hlt stays", {15'd0, HALTED}, 16'd1);
    check("hlt req stays", {15'd0, MEM_REQ}, 16'd0);
    check("hlt pc", PC, 16'h0009);
    $display("halt done pc=%h", PC);

    // Reset out of HALT, then reset again in the middle of a LD memory phase.
    RESET = 1'b0;
    @(negedge CLOCK);
    check("rst2 halted", {15'd0, HALTED}, 16'd0);
    RESET = 1'b1;
    @(negedge CLOCK);
    EA = 16'h0080;
    serve("rst fetch", 16'h0000, 1'b0, 16'h0000, 0);
    @(negedge CLOCK);
    check("mid mem addr", MEM_ADDR, 16'h0080);
    #1 RESET = 1'b0;
    #1 check("mid rst req drop", {15'd0, MEM_REQ}, 16'd0);
    check("mid rst pc", PC, 16'h0000);
    check("mid rst ir", IR, 16'h0000);
    @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    check("restart req", {15'd0, MEM_REQ}, 16'd1);
    check("restart addr", MEM_ADDR, 16'h0000);
    $display("reset restart addr=%h", MEM_ADDR);

`ifdef SEQ_BUS_TIMEOUT_EN
    n = 0;
    while (!HALTED && n < 400) begin
      if (MEM_REQ) n++;
      @(negedge CLOCK);
    end
    check("timeout waits", 16'(n), 16'd255);
    check("timeout bus_err", {15'd0, BUS_ERR}, 16'd1);
    check("timeout req", {15'd0, MEM_REQ}, 16'd0);
    RESET = 1'b0;
    @(negedge CLOCK);
    RESET = 1'b1;
    @(negedge CLOCK);
    check("timeout restart addr", MEM_ADDR, 16'h0000);
    check("timeout restart req", {15'd0, MEM_REQ}, 16'd1);
    check("timeout bus_err clr", {15'd0, BUS_ERR}, 16'd0);
    $display("timeout done waits=%0d", n);
`else
    n = 0;
    repeat (300) @(negedge CLOCK);
    check("no timeout halted", {15'd0, HALTED}, 16'd0);
    check("no timeout bus_err", {15'd0, BUS_ERR}, 16'd0);
    check("no timeout req", {15'd0, MEM_REQ}, 16'd1);
    $display("long wait done req=%0d", MEM_REQ);
`endif

    check("final sb empty", 16'(sb.size()), 16'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
